line_frame_counter: RTL
=======================

# line_frame_counter

Parametrised line/frame counter for the pattern generator timing path, the next generation of the fixed 5-bit 24-line counter. It counts rising edges of `newLine`, exposes the current line index, and emits a one-cycle `endFrame` pulse after a configurable number of lines. It adds a continuous or single-shot frame mode and an optional frame counter. It sits between the line timing generator and the pattern sequencer.

## Interface
- `LINE_W`, 5, width of the line index; legal range 2..16.
- `LINES_PER_FRAME`, 24, lines per frame; legal range 2..2^LINE_W.
- `FRAME_W`, 8, width of `frame_cnt`. Used only with `LFC_FRAME_CNT_EN`.
- `clk`  in  1  master clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enb`  in  1  active-high enable. Low clears the frame in progress.
- `newLine`  in  1  line strobe, level. Only rising edges are counted.
- `single`  in  1  mode: 0 = continuous, 1 = single-shot. Latched on IDLE->COUNT.
- `line_cnt`  out  LINE_W  current line index within the frame, 0..LINES_PER_FRAME-1.
- `endFrame`  out  1  registered one-cycle pulse on frame completion.
- `busy`  out  1  high while in COUNT.
- `frame_cnt`  out  FRAME_W  completed-frame count. Present only with `LFC_FRAME_CNT_EN`.

## Operation
- Edge detect:
  - `nl_d` is a register that samples `newLine` every cycle in all states.
  - `edge = newLine & ~nl_d`.
  - A `newLine` level already high when `enb` rises is not an edge.
- States: IDLE, COUNT, DONE.
- Reset (async): state=IDLE, `line_cnt`=0, `endFrame`=0, `busy`=0, `nl_d`=0, `frame_cnt`=0, mode latch=0.
- `enb`=0 in any state: next state IDLE, `line_cnt`=0, `endFrame`=0. `frame_cnt` is held. This has priority over everything except `rst`.
- IDLE & `enb`=1:
  - Go to COUNT and latch `single`.
  - An edge in this cycle is not counted.
- COUNT, edge, `line_cnt` < LINES_PER_FRAME-1: `line_cnt`+1.
- COUNT, edge, `line_cnt` == LINES_PER_FRAME-1:
  - `line_cnt`=0 and `endFrame`=1 for the next cycle.
  - `frame_cnt`+1, wrapping modulo 2^FRAME_W.
  - Latched single=1: go to DONE. Otherwise stay in COUNT.
- COUNT, no edge: hold.
- DONE:
  - Edges are ignored; `line_cnt`=0, `busy`=0.
  - Exit only via `enb`=0, then IDLE.
- `endFrame` is never high for two consecutive cycles, because an edge needs at least two cycles.
- Changes on `single` outside IDLE->COUNT have no effect.

## Timing
- Edge latency: `newLine` low at edge n-1 and high at edge n (state COUNT) gives updated `line_cnt` and `endFrame` visible after edge n. Registered, latency 1.
- `endFrame` is high for exactly one clock, coincident with `line_cnt` returning to 0.
- `busy` rises one cycle after `enb` rises. It falls one cycle after `enb` falls or after the terminal edge in single mode.
- Reset mid-frame: outputs clear immediately (async). Counting resumes only after `rst` deasserts, then IDLE->COUNT.
- Terminal edge coincident with `enb` falling: `enb`=0 wins. No `endFrame`, no `frame_cnt` increment.

## Configuration
- `LFC_FRAME_CNT_EN` defined: the `frame_cnt` port and register exist and behave as above.
- Undefined: no `frame_cnt` port or register; all other behaviour is identical.

## Test plan
- Reset and defaults:
  - Stimulus: hold `rst`=1 with random inputs.
  - Required: `line_cnt`=0, `endFrame`=0, `busy`=0, `frame_cnt`=0. After release with `enb`=1, `busy`=1 one cycle later.
- Continuous default (24 lines):
  - Stimulus: `enb`=1, `single`=0, 48 `newLine` pulses, each 1 high cycle + 3 low cycles.
  - Required: `line_cnt` steps 0..23 twice. `endFrame` pulses exactly twice, after the 24th and 48th edges. `frame_cnt`=2.
- Level/edge:
  - Stimulus: `newLine` held high for 10 cycles.
  - Required: `line_cnt` increments by 1 only. Also, `newLine` already high when `enb` rises gives no count.
- Single-shot:
  - Stimulus: `single`=1, `LINES_PER_FRAME`=4, 8 edges.
  - Required: one `endFrame` after the 4th edge. `busy`=0 afterwards, `line_cnt` stays 0. Toggling `enb` 0->1 restarts counting.
- Enable abort:
  - Stimulus: drop `enb` at `line_cnt`=23, on the same cycle as the 24th edge.
  - Required: no `endFrame`, `line_cnt`=0, `frame_cnt` unchanged.
- Wrap and config:
  - Stimulus: `FRAME_W`=2, `LINES_PER_FRAME`=2, 10 edges.
  - Required: `frame_cnt` sequence 1,2,3,0,1. Build without `LFC_FRAME_CNT_EN` and confirm all other outputs match.

Source files
------------

// File: rtl/line_frame_counter_if.sv
// line_frame_counter_if
//
// Bundles the line strobe, control inputs and status outputs of
// line_frame_counter so the line timing generator (master) and the counter
// (slave) connect through one port.
//
// Signals:
//   enb        master -> slave  active-high enable; low abandons the frame
//   newLine    master -> slave  line strobe (level); rising edges are counted
//   single     master -> slave  0 = continuous, 1 = single-shot frame mode
//   line_cnt   slave -> master  current line index within the frame
//   endFrame   slave -> master  one-cycle pulse on frame completion
//   busy       slave -> master  high while a frame is being counted
//   frame_cnt  slave -> master  completed-frame count (LFC_FRAME_CNT_EN only)
//
// Optional feature macro: LFC_FRAME_CNT_EN adds the FRAME_W parameter and
// the frame_cnt signal.

interface line_frame_counter_if #(
    parameter int LINE_W = 5
`ifdef LFC_FRAME_CNT_EN
    ,
    parameter int FRAME_W = 8
`endif
);

    logic              enb;
    logic              newLine;
    logic              single;
    logic [LINE_W-1:0] line_cnt;
    logic              endFrame;
    logic              busy;
`ifdef LFC_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt;
`endif

    modport master (
        output enb,
        output newLine,
        output single,
        input  line_cnt,
        input  endFrame,
`ifdef LFC_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  busy
    );

    modport slave (
        input  enb,
        input  newLine,
        input  single,
        output line_cnt,
        output endFrame,
`ifdef LFC_FRAME_CNT_EN
        output frame_cnt,
`endif
        output busy
    );

endinterface

// File: rtl/line_frame_counter.sv
// line_frame_counter
//
// Counts rising edges of newLine and reports the line index within a frame
// of LINES_PER_FRAME lines. On the last line's edge the index returns to 0
// and endFrame pulses for one cycle. In single-shot mode the counter parks
// in DONE after one frame until enb is dropped.
//
// Ports:
//   clk  master clock, rising edge
//   rst  asynchronous active-high reset
//   bus  line_frame_counter_if.slave: enb, newLine, single in;
//        line_cnt, endFrame, busy (and frame_cnt) out
//
// Parameters:
//   LINE_W           width of line_cnt (2..16)
//   LINES_PER_FRAME  lines per frame (2..2^LINE_W)
//   FRAME_W          width of frame_cnt
//
// Optional feature macro: LFC_FRAME_CNT_EN enables the completed-frame
// counter (frame_cnt), which wraps modulo 2^FRAME_W.

module line_frame_counter #(
    parameter int LINE_W          = 5,
    parameter int LINES_PER_FRAME = 24,
    parameter int FRAME_W         = 8
) (
    input logic                clk,
    input logic                rst,
    line_frame_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);

    // Catch illegal configurations at elaboration time.
    if (LINE_W < 2 || LINE_W > 16) begin : g_bad_line_w
        $error("line_frame_counter: LINE_W must be 2..16");
    end
    if (LINES_PER_FRAME < 2 || LINES_PER_FRAME > (1 << LINE_W)) begin : g_bad_lpf
        $error("line_frame_counter: LINES_PER_FRAME must be 2..2^LINE_W");
    end
    if (FRAME_W < 1) begin : g_bad_frame_w
        $error("line_frame_counter: FRAME_W must be at least 1");
    end

    state_t            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              end_q, end_d;
    logic              busy_q, busy_d;
    logic              nl_q, nl_d;
    logic              mode_q, mode_d;
    logic              new_line_edge;
`ifdef LFC_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_q, frame_d;
`endif

    // nl_q tracks newLine in every state, so a level that is already high
    // when counting starts never looks like a fresh edge.
    assign new_line_edge = bus.newLine & ~nl_q;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        end_d   = 1'b0;
        nl_d    = bus.newLine;
        mode_d  = mode_q;
`ifdef LFC_FRAME_CNT_EN
        frame_d = frame_q;
`endif
        if (!bus.enb) begin
            // Dropping enable abandons the frame, even on its terminal edge.
            state_d = IDLE;
            line_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The mode is captured only here; an edge in this cycle
                    // is deliberately not counted.
                    state_d = COUNT;
                    mode_d  = bus.single;
                end
                COUNT: begin
                    if (new_line_edge) begin
                        if (line_q == LAST_LINE) begin
                            line_d = '0;
                            end_d  = 1'b1;
`ifdef LFC_FRAME_CNT_EN
                            frame_d = frame_q + FRAME_W'(1);
`endif
                            if (mode_q) begin
                                state_d = DONE;
                            end
                        end else begin
                            line_d = line_q + LINE_W'(1);
                        end
                    end
                end
                DONE: begin
                    line_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    line_d  = '0;
                end
            endcase
        end
        // busy is registered from the next state so it tracks COUNT exactly.
        busy_d = (state_d == COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            nl_q    <= 1'b0;
            mode_q  <= 1'b0;
`ifdef LFC_FRAME_CNT_EN
            frame_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            nl_q    <= nl_d;
            mode_q  <= mode_d;
`ifdef LFC_FRAME_CNT_EN
            frame_q <= frame_d;
`endif
        end
    end

    assign bus.line_cnt = line_q;
    assign bus.endFrame = end_q;
    assign bus.busy     = busy_q;
`ifdef LFC_FRAME_CNT_EN
    assign bus.frame_cnt = frame_q;
`endif

endmodule
